// File: rtl/router_fifo_param.sv
// -----------------------------------------------------------------------------
// router_fifo_param
// Per-port packet FIFO for the router. Each entry stores {hdr, data}. The hdr
// bit is the write-side lfd_state, so the packet boundary travels with the
// payload. The FIFO also reports its fill level, almost-full/empty, the number
// of stored headers, and sticky overflow/underflow flags.
//
// Ports
//   clk           rising-edge clock
//   resetn        synchronous reset, ACTIVE-HIGH despite the name
//   soft_reset    synchronous flush, active-high (lower priority than resetn)
//   wr_en         write request
//   lfd_state     current write is a packet header byte
//   data_in       write data (DATA_W)
//   rd_en         read request
//   data_out      registered read data (DATA_W)
//   data_out_hdr  header tag of the entry on data_out
//   data_valid    one-cycle pulse, data_out/data_out_hdr updated this cycle
//   empty/full    fill_level == 0 / fill_level == DEPTH
//   almost_empty  fill_level <= AE_THRESH
//   almost_full   fill_level >= AF_THRESH
//   fill_level    stored entries (AW+1 bits)
//   pkt_count     stored entries whose header tag is set (AW+1 bits)
//   overflow      sticky, set when a write is attempted while full
//   underflow     sticky, set when a read is attempted while empty
// -----------------------------------------------------------------------------
module router_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     soft_reset,
   input  logic                     wr_en,
   input  logic                     lfd_state,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        data_out,
   output logic                     data_out_hdr,
   output logic                     data_valid,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [$clog2(DEPTH):0]   pkt_count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_AF   = (AW+1)'(AF_THRESH);
   localparam logic [AW:0]   LVL_AE   = (AW+1)'(AE_THRESH);

   logic [DATA_W:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            wr_acc;
   logic            rd_acc;
   logic            rd_hdr;
   logic [AW:0]     fill_next;
   logic [AW:0]     pkt_next;

   // Status flags decode only the registered count, so full/empty never
   // depend on pointer comparison.
   assign empty        = (fill_level == {(AW+1){1'b0}});
   assign full         = (fill_level == LVL_FULL);
   assign almost_empty = (fill_level <= LVL_AE);
   assign almost_full  = (fill_level >= LVL_AF);

   // A write while full is dropped even if a read is accepted in the same
   // cycle, because full comes from the count before the edge.
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;
   assign rd_hdr = mem[rd_ptr][DATA_W];

   // Next fill level and header count. Simultaneous increment and decrement
   // cancel out.
   always_comb begin
      fill_next = fill_level;
      pkt_next  = pkt_count;
      case ({wr_acc, rd_acc})
         2'b10:   fill_next = fill_level + CNT_ONE;
         2'b01:   fill_next = fill_level - CNT_ONE;
         default: fill_next = fill_level;
      endcase
      case ({wr_acc & lfd_state, rd_acc & rd_hdr})
         2'b10:   pkt_next = pkt_count + CNT_ONE;
         2'b01:   pkt_next = pkt_count - CNT_ONE;
         default: pkt_next = pkt_count;
      endcase
   end

   // Storage array. It is not reset, and writes are suppressed during either
   // reset.
   always_ff @(posedge clk) begin
      if (!resetn && !soft_reset && wr_acc) begin
         mem[wr_ptr] <= {lfd_state, data_in};
      end
   end

   // Pointers, counters, read-data register and sticky error flags.
   always_ff @(posedge clk) begin
      if (resetn || soft_reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill_level   <= '0;
         pkt_count    <= '0;
         data_out     <= '0;
         data_out_hdr <= 1'b0;
         data_valid   <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         fill_level <= fill_next;
         pkt_count  <= pkt_next;
         data_valid <= rd_acc;
         overflow   <= overflow  | (wr_en & full);
         underflow  <= underflow | (rd_en & empty);
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            {data_out_hdr, data_out} <= mem[rd_ptr];
            rd_ptr                   <= rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_router_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_router_fifo_param
// Self-checking bench for router_fifo_param. The main instance uses the
// default parameters (DATA_W=8, DEPTH=16). A second instance uses DATA_W=16
// and DEPTH=4. A queue-based reference model predicts every output of the
// main instance on every cycle. A table of vectors and hand-written sequences
// add fixed expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_router_fifo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance signals
   logic       resetn = 1'b1, soft_reset = 1'b0, wr_en = 1'b0, lfd_state = 1'b0, rd_en = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       data_out_hdr, data_valid, empty, full, almost_empty, almost_full;
   logic [4:0] fill_level, pkt_count;
   logic       overflow, underflow;

   // small instance signals
   logic        b_resetn = 1'b1, b_soft_reset = 1'b0, b_wr_en = 1'b0, b_lfd = 1'b0, b_rd_en = 1'b0;
   logic [15:0] b_data_in = 16'h0000;
   logic [15:0] b_data_out;
   logic        b_hdr, b_valid, b_empty, b_full, b_ae, b_af;
   logic [2:0]  b_fill, b_pkt;
   logic        b_ovf, b_udf;

   router_fifo_param dut (
      .clk(clk), .resetn(resetn), .soft_reset(soft_reset), .wr_en(wr_en),
      .lfd_state(lfd_state), .data_in(data_in), .rd_en(rd_en),
      .data_out(data_out), .data_out_hdr(data_out_hdr), .data_valid(data_valid),
      .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
      .fill_level(fill_level), .pkt_count(pkt_count),
      .overflow(overflow), .underflow(underflow)
   );

   router_fifo_param #(.DATA_W(16), .DEPTH(4)) dut_b (
      .clk(clk), .resetn(b_resetn), .soft_reset(b_soft_reset), .wr_en(b_wr_en),
      .lfd_state(b_lfd), .data_in(b_data_in), .rd_en(b_rd_en),
      .data_out(b_data_out), .data_out_hdr(b_hdr), .data_valid(b_valid),
      .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af),
      .fill_level(b_fill), .pkt_count(b_pkt),
      .overflow(b_ovf), .underflow(b_udf)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (main instance) ----------------
   logic [8:0] q[$];
   logic [7:0] m_dout = 8'h00;
   logic       m_hdr = 1'b0, m_dv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

   function automatic int model_pkts();
      int n = 0;
      foreach (q[i]) if (q[i][8]) n++;
      return n;
   endfunction

   task automatic check_model();
      int n;
      n = q.size();
      chk("fill_level",   fill_level,   n);
      chk("pkt_count",    pkt_count,    model_pkts());
      chk("empty",        empty,        (n == 0));
      chk("full",         full,         (n == 16));
      chk("almost_empty", almost_empty, (n <= 2));
      chk("almost_full",  almost_full,  (n >= 14));
      chk("data_valid",   data_valid,   m_dv);
      chk("data_out",     data_out,     m_dout);
      chk("data_out_hdr", data_out_hdr, m_hdr);
      chk("overflow",     overflow,     m_ovf);
      chk("underflow",    underflow,    m_udf);
   endtask

   // Apply one cycle of stimulus, advance the model, compare everything.
   task automatic step(input logic rst, input logic sr, input logic wr, input logic lfd,
                       input logic [7:0] din, input logic rd);
      logic was_full, was_empty;
      logic [8:0] e;
      resetn = rst; soft_reset = sr; wr_en = wr; lfd_state = lfd; data_in = din; rd_en = rd;
      @(posedge clk);
      #1;
      if (rst || sr) begin
         q.delete();
         m_dout = 8'h00; m_hdr = 1'b0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         was_full  = (q.size() == 16);
         was_empty = (q.size() == 0);
         if (wr && was_full) m_ovf = 1'b1;
         if (rd && was_empty) m_udf = 1'b1;
         m_dv = rd && !was_empty;
         if (rd && !was_empty) begin
            e = q.pop_front();
            m_hdr = e[8];
            m_dout = e[7:0];
         end
         if (wr && !was_full) q.push_back({lfd, din});
      end
      check_model();
      resetn = 1'b0; soft_reset = 1'b0; wr_en = 1'b0; lfd_state = 1'b0; rd_en = 1'b0;
   endtask

   // ---------------- vector table (basic packet + underflow) ----------------
   typedef struct {
      logic       wr, lfd, rd;
      logic [7:0] din;
      int         e_fill, e_pkt;
      logic       e_dv;
      logic [7:0] e_dout;
      logic       e_hdr, e_empty, e_udf;
   } vec_t;

   vec_t tbl[8];

   task automatic step_b(input logic rst, input logic wr, input logic lfd,
                         input logic [15:0] din, input logic rd);
      b_resetn = rst; b_wr_en = wr; b_lfd = lfd; b_data_in = din; b_rd_en = rd;
      @(posedge clk);
      #1;
      b_resetn = 1'b0; b_wr_en = 1'b0; b_lfd = 1'b0; b_rd_en = 1'b0;
   endtask

   initial begin
      //            wr    lfd   rd    din    fill pkt dv    dout   hdr   empty udf
      tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h03, 1, 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 8'hAA, 2, 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h55, 3, 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 2, 0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1};

      // reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_ae", almost_empty, 1'b1);
      chk("rst_af", almost_full, 1'b0);

      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, tbl[i].wr, tbl[i].lfd, tbl[i].din, tbl[i].rd);
         chk("tbl_fill",  fill_level,   tbl[i].e_fill);
         chk("tbl_pkt",   pkt_count,    tbl[i].e_pkt);
         chk("tbl_dv",    data_valid,   tbl[i].e_dv);
         chk("tbl_dout",  data_out,     tbl[i].e_dout);
         chk("tbl_hdr",   data_out_hdr, tbl[i].e_hdr);
         chk("tbl_empty", empty,        tbl[i].e_empty);
         chk("tbl_udf",   underflow,    tbl[i].e_udf);
      end

      // fill to full, overflow, then read the first byte back
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 1'b1, (i % 4 == 0), 8'h10 + 8'(i), 1'b0);
         if (i == 12) chk("af_at_13", almost_full, 1'b0);
         if (i == 13) chk("af_at_14", almost_full, 1'b1);
         if (i == 14) chk("full_at_15", full, 1'b0);
      end
      chk("full_at_16", full, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE, 1'b0);
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_fill", fill_level, 5'd16);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("first_out", data_out, 8'h10);
      chk("first_hdr", data_out_hdr, 1'b1);

      // full with a simultaneous write and read: the write is dropped
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 1'b1);
      chk("full_wr_rd_fill", fill_level, 5'd15);

      // simultaneous read/write at level 5 across a pointer wrap
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, (i == 0), 8'h40 + 8'(i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b1, (i % 3 == 0), 8'h80 + 8'(i), 1'b1);
         chk("simul_fill", fill_level, 5'd5);
      end
      chk("simul_last_out", data_out, 8'h80 + 8'd14);

      // soft reset with wr_en, 6 entries / 2 headers stored, overflow set
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, (i == 10 || i == 13), 8'hC0 + 8'(i), 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("pre_sr_fill", fill_level, 5'd6);
      chk("pre_sr_pkt", pkt_count, 5'd2);
      chk("pre_sr_ovf", overflow, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
      chk("sr_fill", fill_level, 5'd0);
      chk("sr_pkt", pkt_count, 5'd0);
      chk("sr_ovf", overflow, 1'b0);
      chk("sr_dout", data_out, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("sr_no_write", empty, 1'b1);

      // randomized phases: write-biased, balanced, read-biased
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 200; i++) begin
            int wp, rp;
            wp = (ph == 0) ? 80 : (ph == 1) ? 50 : 25;
            rp = (ph == 0) ? 25 : (ph == 1) ? 50 : 80;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < wp), ($urandom_range(0, 3) == 0),
                 8'($urandom), ($urandom_range(0, 99) < rp));
         end
      end

      // DATA_W=16 / DEPTH=4 instance
      step_b(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk("b_rst_empty", b_empty, 1'b1);
      step_b(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0);
      chk("b_af_at_1", b_af, 1'b0);
      step_b(1'b0, 1'b1, 1'b0, 16'h1234, 1'b0);
      chk("b_af_at_2", b_af, 1'b1);
      step_b(1'b0, 1'b1, 1'b0, 16'h5678, 1'b0);
      chk("b_full_at_3", b_full, 1'b0);
      step_b(1'b0, 1'b1, 1'b1, 16'h9ABC, 1'b0);
      chk("b_full_at_4", b_full, 1'b1);
      chk("b_fill_4", b_fill, 3'd4);
      chk("b_pkt_2", b_pkt, 3'd2);
      step_b(1'b0, 1'b1, 1'b0, 16'hDEAD, 1'b0);
      chk("b_ovf", b_ovf, 1'b1);
      step_b(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("b_data", b_data_out, 16'hBEEF);
      chk("b_hdr", b_hdr, 1'b1);
      chk("b_valid", b_valid, 1'b1);
      chk("b_fill_3", b_fill, 3'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/router_fifo_param.md
Name: router_fifo_param

Overview:
- Parametrised successor to the router's per-port packet FIFO. Generic data width and depth.
- Each entry carries a header tag (set from lfd_state), so the packet boundary travels with the data.
- Adds fill-level, almost-full/empty, packet-count and sticky error outputs.
- Simultaneous read/write is handled exactly. Sits between the router's input demux/FSM (write side) and each output port's read logic.

Parameters:
- DATA_W, 8, payload width in bits.
- DEPTH, 16, number of entries; must be a power of 2 and ≥4.
- AW, log2(DEPTH), pointer width; derived, not overridden.
- AF_THRESH, DEPTH-2, almost_full asserts when fill_level ≥ AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when fill_level ≤ AE_THRESH.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous reset, active-high despite the name; sampled on posedge clk.
- soft_reset  in  1  synchronous flush, active-high.
- wr_en  in  1  write request.
- lfd_state  in  1  marks the current write as a packet header byte.
- data_in  in  DATA_W  write data.
- rd_en  in  1  read request.
- data_out  out  DATA_W  registered read data.
- data_out_hdr  out  1  header tag of the entry presented on data_out.
- data_valid  out  1  one-cycle pulse: data_out/data_out_hdr updated this cycle.
- empty  out  1  fill_level==0.
- full  out  1  fill_level==DEPTH.
- almost_empty  out  1  fill_level ≤ AE_THRESH.
- almost_full  out  1  fill_level ≥ AF_THRESH.
- fill_level  out  AW+1  number of stored entries.
- pkt_count  out  AW+1  number of stored entries with header tag set.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Storage: DEPTH entries of DATA_W+1 bits, {hdr, data}.
- Pointers: wr_ptr/rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0.
- Reset (resetn=1):
  - Pointers, fill_level, pkt_count, data_out, data_out_hdr, data_valid, overflow and underflow all go to 0.
  - Memory contents are don't-care.
  - Result: empty=1, full=0, almost_empty=1, almost_full=0.
- Priority: resetn > soft_reset > normal operation.
- soft_reset: same clears as reset in that cycle; any wr_en/rd_en in that cycle is ignored.
- Write accept: wr_acc = wr_en & ~full.
  - full is evaluated from the registered count before the edge.
  - A write while full is dropped even if a read is accepted in the same cycle.
- Read accept: rd_acc = rd_en & ~empty.
- Accepted write: mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr increments.
- Accepted read:
  - {data_out_hdr, data_out} <= mem[rd_ptr]; rd_ptr increments.
  - data_valid=1 the next cycle only. Read latency is 1 cycle from rd_en to data.
- No accepted read: data_out and data_out_hdr hold their last value; data_valid=0.
- fill_level update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both are accepted in the same cycle.
- pkt_count update:
  - +1 if wr_acc & lfd_state.
  - -1 if rd_acc & mem[rd_ptr].hdr.
  - Net change applied when both occur.
- Sticky error flags:
  - overflow set on wr_en & full.
  - underflow set on rd_en & empty.
  - Both cleared only by resetn or soft_reset.
- Status outputs (empty, full, almost_*) are combinational decodes of the registered fill_level; no pointer-compare logic.
- Same-address hazard: none. Read and write pointers are equal only when empty (no read accepted) or full (no write accepted).
- Reset mid-packet discards all stored data. No partial-packet recovery.

Test Plan:
- Reset, then write 3 bytes: header 0x03, then 0xAA, 0x55 (lfd_state=1 on the first byte only). Required: fill_level=3, pkt_count=1, empty=0. Then read 3 times: data_out = 0x03 (hdr=1), 0xAA (hdr=0), 0x55 (hdr=0), each with data_valid one cycle after rd_en; afterwards empty=1, pkt_count=0.
- Fill with 16 writes (DEPTH=16). Required: full=1, almost_full asserted at fill_level=14. A 17th write sets overflow=1 and leaves fill_level=16. A read then returns the first byte written.
- Simultaneous wr_en and rd_en at fill_level=5 for 20 cycles. Required: fill_level stays 5, and pointers wrap past 15→0 with data returned in order.
- rd_en while empty. Required: underflow=1, data_out holds its previous value, data_valid=0, fill_level=0.
- With 6 entries (2 headers) stored and overflow set, assert soft_reset together with wr_en. Required next cycle: fill_level=0, pkt_count=0, overflow=0, data_out=0, and no write stored.
- Parameter sweep DATA_W=16, DEPTH=4. Required: full after 4 writes, almost_full at 2, and data 0xBEEF round-trips intact.
